// File: rtl/eric_clapton_pkg.sv
// Shared types and SHA-256 style boolean helpers for the eric_clapton mixer.
// ch_f/maj_f are kept here so the SHA round logic can reuse them.
package eric_clapton_pkg;

  localparam int W = 4;

  typedef logic [W-1:0] word_t;

  // Ch: each bit of x picks y (when 1) or z (when 0)
  function automatic word_t ch_f(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  // Maj: bitwise majority vote of the three words
  function automatic word_t maj_f(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/eric_clapton_if.sv
// Bundle between the register stage and the combinational mixer.
// The master drives the registered words and the slave returns their parity.
interface eric_clapton_if;
  import eric_clapton_pkg::*;

  word_t x;
  word_t y;
  word_t z;
  logic  parity;

  modport master (output x, output y, output z, input parity);
  modport slave  (input x, input y, input z, output parity);

endinterface

// File: rtl/eric_clapton_mix.sv
// Pure combinational mixer: parity of (Ch + Maj) mod 2**W.
module eric_clapton_mix
  import eric_clapton_pkg::*;
(
  eric_clapton_if.slave mix_bus
);

  word_t sum;

  // The sum is declared W bits wide, so the carry out drops off naturally
  always_comb begin
    sum = ch_f(mix_bus.x, mix_bus.y, mix_bus.z) + maj_f(mix_bus.x, mix_bus.y, mix_bus.z);
  end

  assign mix_bus.parity = ^sum;

endmodule

// File: rtl/eric_clapton_core.sv
// Two-stage pipelined Ch/Maj parity mixer; one result per clock, no handshake.
// Port names match the integration names of the eric_clapton instance.
module eric_clapton_core
  import eric_clapton_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  word_t A_e,
  input  word_t B_e,
  input  word_t C_e,
  output logic  Yout
);

  word_t a_q;
  word_t b_q;
  word_t c_q;

  eric_clapton_if mix_bus ();

  assign mix_bus.x = a_q;
  assign mix_bus.y = b_q;
  assign mix_bus.z = c_q;

  eric_clapton_mix u_mix (
    .mix_bus (mix_bus)
  );

  // Both stages clear together, so in-flight data is discarded on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      Yout <= 1'b0;
    end else begin
      a_q  <= A_e;
      b_q  <= B_e;
      c_q  <= C_e;
      Yout <= mix_bus.parity;
    end
  end

endmodule

// File: tb/tb_eric_clapton_core.sv
// Directed and random self-checking bench for eric_clapton_core.
module tb_eric_clapton_core;
  import eric_clapton_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  eric_clapton_if stim ();

  eric_clapton_core dut (
    .clk   (clk),
    .reset (reset),
    .A_e   (stim.x),
    .B_e   (stim.y),
    .C_e   (stim.z),
    .Yout  (stim.parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input word_t a, input word_t b, input word_t c);
    stim.x = a;
    stim.y = b;
    stim.z = c;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial golden model: per-bit select/majority, integer add, bit count
  function automatic logic model_parity(word_t a, word_t b, word_t c);
    int ch_v;
    int maj_v;
    int s;
    int ones;
    ch_v = 0;
    maj_v = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) ch_v += (b[i] ? (1 << i) : 0);
      else      ch_v += (c[i] ? (1 << i) : 0);
      if ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2) maj_v += (1 << i);
    end
    s = (ch_v + maj_v) % 16;
    ones = 0;
    for (int i = 0; i < W; i++) ones += (s >> i) & 1;
    return logic'(ones % 2);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(word_t'($urandom_range(0, 15)), word_t'($urandom_range(0, 15)), word_t'($urandom_range(0, 15)));
    #1;
    checks++;
    if (stim.parity !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_immediate: Yout=%b expected 0", stim.parity);
    end
    tick();
    drive(4'b0000, 4'b0000, 4'b0000);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (stim.parity !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_release_edge%0d: Yout=%b expected 0", k + 1, stim.parity);
      end
    end
  endtask

  task automatic test_zeros();
    drive(4'b0000, 4'b0000, 4'b0001);
    tick();
    tick();
    checks++;
    if (stim.parity !== 1'b1) begin
      fails++;
      $display("[TB] FAIL zeros: Yout=%b expected 1", stim.parity);
    end
  endtask

  task automatic test_wrap();
    drive(4'b1111, 4'b1010, 4'b0101);
    tick();
    tick();
    checks++;
    if (stim.parity !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap: Yout=%b expected 0", stim.parity);
    end
  endtask

  task automatic test_carry();
    drive(4'b1100, 4'b1010, 4'b0110);
    tick();
    tick();
    checks++;
    if (stim.parity !== 1'b1) begin
      fails++;
      $display("[TB] FAIL carry: Yout=%b expected 1", stim.parity);
    end
  endtask

  task automatic test_back_to_back();
    word_t va[3];
    word_t vb[3];
    word_t vc[3];
    logic  exp_y[3];
    va = '{4'b0000, 4'b1111, 4'b1100};
    vb = '{4'b0000, 4'b1010, 4'b1010};
    vc = '{4'b0001, 4'b0101, 4'b0110};
    exp_y = '{1'b1, 1'b0, 1'b1};
    // Hold wrap vector first so the stream starts from a known Yout=0
    drive(4'b1111, 4'b1010, 4'b0101);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(va[i], vb[i], vc[i]);
      else       drive(4'b1111, 4'b1010, 4'b0101);
      tick();
      if (i >= 1) begin
        checks++;
        if (stim.parity !== exp_y[i-1]) begin
          fails++;
          $display("[TB] FAIL stream_%0d: Yout=%b expected %b", i - 1, stim.parity, exp_y[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    drive(4'b0000, 4'b0000, 4'b0001);
    tick();
    tick();
    checks++;
    if (stim.parity !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_pre: Yout=%b expected 1", stim.parity);
    end
    drive(4'b1100, 4'b1010, 4'b0110);
    tick();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (stim.parity !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_async: Yout=%b expected 0", stim.parity);
    end
    drive(4'b0000, 4'b0000, 4'b0000);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (stim.parity !== 1'b0) begin
        fails++;
        $display("[TB] FAIL mid_discard_edge%0d: Yout=%b expected 0", k + 1, stim.parity);
      end
    end
    drive(4'b0000, 4'b0000, 4'b0001);
    tick();
    tick();
    checks++;
    if (stim.parity !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_recover: Yout=%b expected 1", stim.parity);
    end
  endtask

  task automatic test_random();
    logic  hist[$];
    logic  exp_y;
    word_t a;
    word_t b;
    word_t c;
    for (int i = 0; i < 1001; i++) begin
      a = word_t'($urandom_range(0, 15));
      b = word_t'($urandom_range(0, 15));
      c = word_t'($urandom_range(0, 15));
      drive(a, b, c);
      hist.push_back(model_parity(a, b, c));
      tick();
      if (hist.size() == 2) begin
        exp_y = hist.pop_front();
        checks++;
        if (stim.parity !== exp_y) begin
          fails++;
          $display("[TB] FAIL random_%0d: Yout=%b expected %b", i - 1, stim.parity, exp_y);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_zeros();
    test_wrap();
    test_carry();
    test_back_to_back();
    test_reset_mid_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
